seq_det_scheduler: RTL
======================

SEQ_DET_SCHEDULER -- requirements
Module: seq_det_scheduler

Interface
REQ-001 Parameter NCH, 4, number of serial requester channels; legal range 2..8.
REQ-002 Parameter PATTERN, 4'b1101, power-up/reset detection pattern; bit 3 is the oldest bit.
REQ-003 Parameter OVERLAP, 1, 1 = overlapping detection, 0 = history cleared after a match.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  1 = arbitrate and detect; 0 = idle, no grants.
REQ-007 clear  input  1  synchronous clear of all channel histories and match counters.
REQ-008 in_valid  input  NCH  per-channel bit offered.
REQ-009 in_bit  input  NCH  per-channel serial data bit.
REQ-010 in_ready  output  NCH  one-hot grant; a bit transfers when in_valid[i] and in_ready[i] are both 1.
REQ-011 cfg_we  input  1  pattern write strobe.
REQ-012 cfg_pattern  input  4  new pattern value.
REQ-013 match_valid  output  1  registered one-cycle pulse per detected pattern.
REQ-014 match_ch  output  3  channel index of the current match_valid pulse.
REQ-015 busy  output  1  1 when the FSM is in RUN.
REQ-016 cnt_sel  input  3  counter select; cnt_out  output  8  combinational match count of the selected channel.

Function
REQ-017 FSM states IDLE and RUN: IDLE->RUN when enable=1; RUN->IDLE when enable=0; the transition takes effect at the clock edge.
REQ-018 In IDLE, in_ready shall be all-zero.
REQ-019 In RUN, at most one in_ready bit shall be 1 per cycle, and it is asserted only for a channel with in_valid=1.
REQ-020 Arbitration: round-robin; the search starts at the channel after the last granted channel, wrapping from NCH-1 to 0; after reset the search starts at channel 0.
REQ-021 The round-robin pointer shall update only on a transfer.
REQ-022 in_ready shall be combinational from in_valid, the pointer and the state (zero-latency grant).
REQ-023 Each channel shall hold a context of its 3 most recent accepted bits plus a fill count, saturating at 3.
REQ-024 A match on channel i: a transfer with fill count = 3 and {history, in_bit[i]} == the active pattern.
REQ-025 On a match, match_valid=1 and match_ch=i on the cycle after the transfer; otherwise match_valid=0.
REQ-026 A transfer shall update only the granted channel's context; all other channels' contexts are unchanged.
REQ-027 OVERLAP=1: after a match, the history shifts normally (1101101 yields 2 matches).
REQ-028 OVERLAP=0: after a match, history and fill count clear to 0 (1101101 yields 1 match).
REQ-029 Each channel has an 8-bit match counter that increments on its match and saturates at 255.
REQ-030 cnt_sel >= NCH shall return cnt_out = 0.
REQ-031 cfg_we in IDLE loads cfg_pattern into the active pattern on the next edge.
REQ-032 cfg_we in RUN shall be ignored.
REQ-033 clear=1 zeroes all contexts and counters on the next edge, in any state, and suppresses any match from a same-cycle transfer.
REQ-034 clear shall not change the active pattern or the round-robin pointer.
REQ-035 Leaving RUN retains contexts: a stream resumed after IDLE continues detection across the gap.

Reset
REQ-036 rst=0 asynchronously forces: state=IDLE; in_ready=0; match_valid=0; match_ch=0; busy=0.
REQ-037 rst=0 asynchronously forces: all contexts and counters=0; pointer=0; active pattern=PATTERN.
REQ-038 rst asserted mid-stream discards partial histories; after release, no match occurs until 4 new bits are accepted on a channel.

Verification
REQ-039 Single channel 0, enable=1, bits 1,1,0,1 -> match_valid pulse with match_ch=0 one cycle after the 4th transfer; cnt_sel=0 gives cnt_out=1.
REQ-040 All 4 channels valid every cycle -> grants 0,1,2,3,0,...; channel 2 alone dropping valid for one cycle -> grants skip to 3, with no lost or duplicated transfers.
REQ-041 Channels 1 and 3 interleaved, each sending 1101101 -> OVERLAP=1: 2 matches each, ch1/ch3 tagged correctly; OVERLAP=0: 1 match each.
REQ-042 cfg_we with 4'b0110 while busy=1 -> pattern unchanged; same write in IDLE -> stream 0110 matches and stream 1101 no longer matches.
REQ-043 Pattern 1111 with 300 ones on channel 0 -> counter saturates at 255 and stays there; clear=1 -> cnt_out=0 on the next cycle.
REQ-044 Assert rst after bits 1,1,0 on channel 0, then release and send 1 -> no match; then 1,1,0,1 -> a match.

Source files
------------

// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: round-robin arbiter over NCH serial bit streams with a
// per-channel 4-bit pattern detector and saturating per-channel match counters.
module seq_det_scheduler #(
    parameter int          NCH     = 4,
    parameter logic [3:0]  PATTERN = 4'b1101,
    parameter bit          OVERLAP = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           clear,
    input  logic [NCH-1:0] in_valid,
    input  logic [NCH-1:0] in_bit,
    output logic [NCH-1:0] in_ready,
    input  logic           cfg_we,
    input  logic [3:0]     cfg_pattern,
    output logic           match_valid,
    output logic [2:0]     match_ch,
    output logic           busy,
    input  logic [2:0]     cnt_sel,
    output logic [7:0]     cnt_out
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;          // first channel examined by the next search
    logic [3:0]  pat_q, pat_d;
    logic [2:0]  hist_q [NCH];
    logic [2:0]  hist_d [NCH];
    logic [1:0]  fill_q [NCH];
    logic [1:0]  fill_d [NCH];
    logic [7:0]  cnt_q  [NCH];
    logic [7:0]  cnt_d  [NCH];
    logic        match_valid_q, match_valid_d;
    logic [2:0]  match_ch_q, match_ch_d;

    logic [NCH-1:0] grant;
    logic           gnt_any;
    logic [2:0]     gnt_idx;
    int unsigned    idx;
    logic           hit;

    // Round-robin search from ptr_q, wrapping; only granted while in RUN
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (state_q == S_RUN) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                idx = {29'd0, ptr_q} + k;
                if (idx >= NCH) begin
                    idx = idx - NCH;
                end
                if (!gnt_any && in_valid[idx]) begin
                    gnt_any    = 1'b1;
                    gnt_idx    = 3'(idx);
                    grant[idx] = 1'b1;
                end
            end
        end
    end

    assign in_ready = grant;

    // Next-state: FSM, pointer, pattern, granted channel context, counters, match pulse
    always_comb begin
        state_d       = enable ? S_RUN : S_IDLE;
        ptr_d         = ptr_q;
        pat_d         = pat_q;
        match_valid_d = 1'b0;
        match_ch_d    = '0;
        hit           = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            hist_d[i] = hist_q[i];
            fill_d[i] = fill_q[i];
            cnt_d[i]  = cnt_q[i];
        end

        if (gnt_any) begin
            ptr_d = (gnt_idx == 3'(NCH - 1)) ? '0 : gnt_idx + 3'd1;
        end

        for (int unsigned i = 0; i < NCH; i++) begin
            if (gnt_any && (gnt_idx == 3'(i))) begin
                hit = (fill_q[i] == 2'd3) && ({hist_q[i], in_bit[i]} == pat_q);
                if (hit && !clear) begin
                    match_valid_d = 1'b1;
                    match_ch_d    = 3'(i);
                    if (cnt_q[i] != 8'hFF) begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
                end
                if (hit && !OVERLAP) begin
                    hist_d[i] = '0;
                    fill_d[i] = '0;
                end else begin
                    hist_d[i] = {hist_q[i][1:0], in_bit[i]};
                    if (fill_q[i] != 2'd3) begin
                        fill_d[i] = fill_q[i] + 2'd1;
                    end
                end
            end
        end

        // clear wins over any same-cycle transfer; pattern and pointer are untouched
        if (clear) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                hist_d[i] = '0;
                fill_d[i] = '0;
                cnt_d[i]  = '0;
            end
        end

        if (cfg_we && (state_q == S_IDLE)) begin
            pat_d = cfg_pattern;
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            pat_q         <= PATTERN;
            match_valid_q <= 1'b0;
            match_ch_q    <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                hist_q[i] <= '0;
                fill_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            pat_q         <= pat_d;
            match_valid_q <= match_valid_d;
            match_ch_q    <= match_ch_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                hist_q[i] <= hist_d[i];
                fill_q[i] <= fill_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign match_valid = match_valid_q;
    assign match_ch    = match_ch_q;
    assign busy        = (state_q == S_RUN);

    // Counter readback; out-of-range selects read as zero
    always_comb begin
        cnt_out = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (cnt_sel == 3'(i)) begin
                cnt_out = cnt_q[i];
            end
        end
    end

endmodule
